// File: rtl/pa_cp0_pkg.sv
// Shared definitions for the CP0 LSU drain-request arbiter.
// This covers the FSM encodings and the requester slot indices.
package pa_cp0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b11
    } arb_state_e;

    localparam int unsigned REQ_LPMD  = 32'd0;
    localparam int unsigned REQ_SRST  = 32'd1;
    localparam int unsigned REQ_FENCE = 32'd2;
    localparam int unsigned REQ_SYNC  = 32'd3;

endpackage

// File: rtl/pa_cp0_rr_pick.sv
// Combinational round-robin find-first.
// The search starts one slot above ptr and wraps around.
module pa_cp0_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IW-1:0]      win_idx,
    output logic               any
);

    logic [IW-1:0] pos_s;
    logic          hit_s;

    // Walk the slots from ptr+1 with wrap; the first set bit wins.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        pos_s      = '0;
        hit_s      = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            pos_s             = IW'((int'(ptr) + k) % int'(NUM_REQ));
            hit_s             = !any && req[pos_s];
            win_onehot[pos_s] = win_onehot[pos_s] | hit_s;
            win_idx           = hit_s ? pos_s : win_idx;
            any               = any | hit_s;
        end
    end

endmodule

// File: rtl/pa_cp0_lsu_req_arb.sv
// Arbitrates the CP0 drain requesters (lpmd, srst, fence, sync) onto the single LSU fence/sync channel.
// It runs a round-robin grant, handles the ack handshake with an idle gap, and flags a missing ack.
module pa_cp0_lsu_req_arb #(
    parameter int unsigned         NUM_REQ    = 4,
    parameter logic [NUM_REQ-1:0]  FLUSH_MASK = 4'b1101,
    parameter int unsigned         TIMEOUT    = 1023,
    parameter int unsigned         TO_W       = 10
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [NUM_REQ-1:0] req_is_fence,
    input  logic               rtu_yy_xx_flush,
    input  logic               lsu_cp0_fence_ack,
    input  logic               lsu_cp0_sync_ack,
    output logic               cp0_lsu_fence_req,
    output logic               cp0_lsu_sync_req,
    output logic [NUM_REQ-1:0] req_gnt,
    output logic [NUM_REQ-1:0] req_ack,
    output logic               arb_busy,
    output logic               arb_clk_en,
    output logic               arb_timeout,
    output logic [1:0]         arb_cur_state
);

    import pa_cp0_pkg::*;

    localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] TO_HIT  = TO_W'(TIMEOUT - 32'd1);

    arb_state_e         state_r;
    arb_state_e         next_state_s;
    logic [NUM_REQ-1:0] gnt_r;
    logic               typ_r;
    logic [IW-1:0]      rr_ptr_r;
    logic [TO_W-1:0]    cnt_r;
    logic               timeout_r;

    logic [NUM_REQ-1:0] pick_req_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic [IW-1:0]      win_idx_s;
    logic               any_s;
    logic               load_s;
    logic               ack_match_s;
    logic               flush_drop_s;
    logic               abandon_s;
    logic               to_hit_s;

    // A flush in the pick cycle keeps flushable requesters out of the arbitration.
    assign pick_req_s = req_vld & ~(rtu_yy_xx_flush ? FLUSH_MASK : {NUM_REQ{1'b0}});

    pa_cp0_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req        (pick_req_s),
        .ptr        (rr_ptr_r),
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s),
        .any        (any_s)
    );

    assign load_s       = (state_r == ST_IDLE) && any_s;
    assign ack_match_s  = typ_r ? lsu_cp0_fence_ack : lsu_cp0_sync_ack;
    assign flush_drop_s = rtu_yy_xx_flush && |(gnt_r & FLUSH_MASK);
    assign abandon_s    = ~|(req_vld & gnt_r);
    assign to_hit_s     = (state_r == ST_REQ) && (cnt_r >= TO_HIT);

    // State register.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and ack decode; a matching ack outranks flush and abandon.
    always_comb begin
        next_state_s = state_r;
        req_ack      = '0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_match_s) begin
                    req_ack      = gnt_r;
                    next_state_s = ST_GAP;
                end else if (flush_drop_s || abandon_s) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_GAP:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Grant, request type and round-robin pointer, all loaded together on a pick.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            gnt_r    <= '0;
            typ_r    <= 1'b0;
            rr_ptr_r <= IW'(NUM_REQ - 32'd1);
        end else if (load_s) begin
            gnt_r    <= win_onehot_s;
            typ_r    <= req_is_fence[win_idx_s];
            rr_ptr_r <= win_idx_s;
        end else if (next_state_s != ST_REQ) begin
            gnt_r    <= '0;
            typ_r    <= typ_r;
            rr_ptr_r <= rr_ptr_r;
        end else begin
            gnt_r    <= gnt_r;
            typ_r    <= typ_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Saturating count of REQ cycles, restarted on every new grant.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            cnt_r <= '0;
        end else if (load_s) begin
            cnt_r <= '0;
        end else if ((state_r == ST_REQ) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky missing-ack flag; it only reports and never aborts the request.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            timeout_r <= 1'b0;
        end else if (rtu_yy_xx_flush) begin
            timeout_r <= 1'b0;
        end else if (to_hit_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign cp0_lsu_fence_req = (state_r == ST_REQ) &&  typ_r;
    assign cp0_lsu_sync_req  = (state_r == ST_REQ) && !typ_r;
    assign req_gnt           = gnt_r;
    assign arb_busy          = (state_r != ST_IDLE);
    assign arb_clk_en        = (|req_vld) | arb_busy;
    assign arb_timeout       = timeout_r;
    assign arb_cur_state     = state_r;

endmodule

// File: tb/tb_pa_cp0_lsu_req_arb.sv
// Directed bench for pa_cp0_lsu_req_arb with TIMEOUT = 8.
// Inputs change 1 time unit after each rising edge, and outputs are sampled 1 unit later.
module tb_pa_cp0_lsu_req_arb;

    logic       clk = 1'b0;
    logic       cpurst;
    logic [3:0] req_vld;
    logic [3:0] req_is_fence;
    logic       flush;
    logic       fence_ack;
    logic       sync_ack;
    logic       fence_req;
    logic       sync_req;
    logic [3:0] req_gnt;
    logic [3:0] req_ack;
    logic       arb_busy;
    logic       arb_clk_en;
    logic       arb_timeout;
    logic [1:0] arb_cur_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pa_cp0_lsu_req_arb #(
        .NUM_REQ    (4),
        .FLUSH_MASK (4'b1101),
        .TIMEOUT    (8),
        .TO_W       (4)
    ) dut (
        .forever_cpuclk    (clk),
        .cpurst            (cpurst),
        .req_vld           (req_vld),
        .req_is_fence      (req_is_fence),
        .rtu_yy_xx_flush   (flush),
        .lsu_cp0_fence_ack (fence_ack),
        .lsu_cp0_sync_ack  (sync_ack),
        .cp0_lsu_fence_req (fence_req),
        .cp0_lsu_sync_req  (sync_req),
        .req_gnt           (req_gnt),
        .req_ack           (req_ack),
        .arb_busy          (arb_busy),
        .arb_clk_en        (arb_clk_en),
        .arb_timeout       (arb_timeout),
        .arb_cur_state     (arb_cur_state)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] f, input logic fl,
                         input logic fa, input logic sa);
        req_vld      = v;
        req_is_fence = f;
        flush        = fl;
        fence_ack    = fa;
        sync_ack     = sa;
        #1;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        cpurst = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", arb_cur_state, 2'b00);
        check_val("rst_gnt",   req_gnt,       4'b0000);
        check_val("rst_freq",  fence_req,     1'b0);
        check_val("rst_sreq",  sync_req,      1'b0);
        check_val("rst_ack",   req_ack,       4'b0000);
        check_val("rst_to",    arb_timeout,   1'b0);
        check_val("rst_busy",  arb_busy,      1'b0);
        check_val("rst_clken", arb_clk_en,    1'b0);
        cpurst = 1'b0;

        // 1: single fence requester, ack in cycle 5
        drive(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        check_val("t1_clken", arb_clk_en, 1'b1);
        check_val("t1_c0_freq", fence_req, 1'b0);
        tick();
        check_val("t1_c1_state", arb_cur_state, 2'b01);
        check_val("t1_c1_gnt",   req_gnt,       4'b0100);
        check_val("t1_c1_freq",  fence_req,     1'b1);
        check_val("t1_c1_sreq",  sync_req,      1'b0);
        check_val("t1_c1_busy",  arb_busy,      1'b1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_val("t1_hold_freq", fence_req, 1'b1);
        end
        tick();
        drive(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        check_val("t1_c5_ack",  req_ack,   4'b0100);
        check_val("t1_c5_freq", fence_req, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t1_c6_state", arb_cur_state, 2'b11);
        check_val("t1_c6_freq",  fence_req,     1'b0);
        check_val("t1_c6_gnt",   req_gnt,       4'b0000);
        tick();
        check_val("t1_c7_state", arb_cur_state, 2'b00);

        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;

        // 2: round-robin over four sync requesters
        drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            e = 4'b0001 << (i % 4);
            tick();
            check_val("t2_gnt",  req_gnt,  e);
            check_val("t2_sreq", sync_req, 1'b1);
            tick();
            drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
            check_val("t2_ack", req_ack, e);
            tick();
            drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
            check_val("t2_gap_state", arb_cur_state, 2'b11);
            check_val("t2_gap_lsu",   {fence_req, sync_req}, 2'b00);
            check_val("t2_gap_gnt",   req_gnt, 4'b0000);
            tick();
            check_val("t2_idle_state", arb_cur_state, 2'b00);
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // 3a: flushable requester 3 dropped by flush
        drive(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t3a_gnt", req_gnt, 4'b1000);
        drive(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0);
        check_val("t3a_ack", req_ack, 4'b0000);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t3a_state", arb_cur_state, 2'b11);
        check_val("t3a_gnt0",  req_gnt,       4'b0000);
        tick();
        // 3b: srst requester survives flush
        drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t3b_gnt", req_gnt, 4'b0010);
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t3b_state", arb_cur_state, 2'b01);
        check_val("t3b_sreq",  sync_req,      1'b1);
        drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
        check_val("t3b_ack", req_ack, 4'b0010);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t3b_gap", arb_cur_state, 2'b11);
        tick();

        // 4a: sync ack and flush together on flushable requester 2
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t4a_gnt", req_gnt, 4'b0100);
        drive(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1);
        check_val("t4a_ack", req_ack, 4'b0100);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t4a_gap", arb_cur_state, 2'b11);
        tick();
        // 4b: fence ack ignored during a sync request
        drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t4b_gnt", req_gnt, 4'b0001);
        drive(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_val("t4b_noack", req_ack, 4'b0000);
        tick();
        drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t4b_state", arb_cur_state, 2'b01);
        check_val("t4b_sreq",  sync_req,      1'b1);
        drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
        check_val("t4b_ack", req_ack, 4'b0001);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();

        // 5: timeout after eight unacked REQ cycles
        drive(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_val("t5_freq",  fence_req,   1'b1);
            check_val("t5_to_lo", arb_timeout, 1'b0);
        end
        tick();
        check_val("t5_to_hi", arb_timeout,   1'b1);
        check_val("t5_freq9", fence_req,     1'b1);
        check_val("t5_state", arb_cur_state, 2'b01);
        drive(4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0);
        check_val("t5_ack", req_ack, 4'b1000);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t5_gap",    arb_cur_state, 2'b11);
        check_val("t5_to_gap", arb_timeout,   1'b1);
        tick();
        check_val("t5_to_idle", arb_timeout, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_val("t5_to_clr", arb_timeout, 1'b0);

        // 6: asynchronous reset in REQ with an ack in flight
        drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t6_gnt", req_gnt,  4'b0001);
        check_val("t6_sreq", sync_req, 1'b1);
        cpurst   = 1'b1;
        sync_ack = 1'b1;
        #1;
        check_val("t6_rst_gnt",   req_gnt,       4'b0000);
        check_val("t6_rst_sreq",  sync_req,      1'b0);
        check_val("t6_rst_ack",   req_ack,       4'b0000);
        check_val("t6_rst_busy",  arb_busy,      1'b0);
        check_val("t6_rst_state", arb_cur_state, 2'b00);
        tick();
        cpurst = 1'b0;
        drive(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t6_regnt", req_gnt, 4'b0001);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
